// File: rtl/hpdmc_pkg.sv
// rtl/hpdmc_pkg.sv - shared state encoding and width helpers for the HPDMC DDR write path
package hpdmc_pkg;

  localparam int HPDMC_BYTE_W = 8;
  localparam int HPDMC_CNT_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_PRE  = 3'd2,
    ST_DATA = 3'd3,
    ST_POST = 3'd4
  } wr_state_e;

  // One mask bit per data byte on the DQ bus
  function automatic int dm_width(input int dq_width);
    return dq_width / HPDMC_BYTE_W;
  endfunction

endpackage

// File: rtl/hpdmc_oddr_bank.sv
// rtl/hpdmc_oddr_bank.sv - generic per-bit DDR output register bank, instantiated by the PHY top
module hpdmc_oddr_bank #(
  parameter int WIDTH = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  output logic [WIDTH-1:0] q_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic rise_q;
    logic fall_q;

    // Rising-edge half: launched for the high phase of sys_clk
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) rise_q <= 1'b0;
      else            rise_q <= d0_i[i];
    end

    // Falling-edge half: captured mid-cycle so it is stable for the low phase
    always_ff @(negedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) fall_q <= 1'b0;
      else            fall_q <= d1_i[i];
    end

    assign q_o[i] = sys_clk ? rise_q : fall_q;
  end

endmodule

// File: rtl/hpdmc_ddr_wrpath.sv
// rtl/hpdmc_ddr_wrpath.sv - DDR write burst sequencer producing ODDR-side DQ/DM/DQS values
module hpdmc_ddr_wrpath
  import hpdmc_pkg::*;
#(
  parameter  int DQ_WIDTH    = 16,
  parameter  int BURST_BEATS = 4,
  parameter  int WR_LATENCY  = 1,
  localparam int DM_W        = dm_width(DQ_WIDTH)
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  wr_start,
  output logic                  wr_busy,
  input  logic [2*DQ_WIDTH-1:0] wdata,
  input  logic [2*DM_W-1:0]     wmask,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  output logic [DQ_WIDTH-1:0]   dq_d0,
  output logic [DQ_WIDTH-1:0]   dq_d1,
  output logic [DM_W-1:0]       dm_d0,
  output logic [DM_W-1:0]       dm_d1,
  output logic                  dq_oe,
  output logic                  dqs_d0,
  output logic                  dqs_d1,
  output logic                  dqs_oe,
  output logic                  underrun,
  input  logic                  underrun_clr
);

  localparam logic [HPDMC_CNT_W-1:0] WAIT_LOAD = HPDMC_CNT_W'(WR_LATENCY > 0 ? WR_LATENCY - 1 : 0);
  localparam logic [HPDMC_CNT_W-1:0] PAIR_LOAD = HPDMC_CNT_W'(BURST_BEATS / 2 - 1);
  localparam logic [HPDMC_CNT_W-1:0] CNT_ONE   = HPDMC_CNT_W'(1);

  wr_state_e               state_q;
  logic [HPDMC_CNT_W-1:0]  cnt_q;
  logic [DQ_WIDTH-1:0]     dq_d0_q;
  logic [DQ_WIDTH-1:0]     dq_d1_q;
  logic [DM_W-1:0]         dm_d0_q;
  logic [DM_W-1:0]         dm_d1_q;
  logic                    dq_oe_q;
  logic                    dqs_d0_q;
  logic                    dqs_d1_q;
  logic                    dqs_oe_q;
  logic                    underrun_q;

  // Burst FSM with registered pad outputs: outputs in cycle n+1 reflect state/inputs of cycle n
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dq_d0_q    <= '0;
      dq_d1_q    <= '0;
      dm_d0_q    <= '1;
      dm_d1_q    <= '1;
      dq_oe_q    <= 1'b0;
      dqs_d0_q   <= 1'b0;
      dqs_d1_q   <= 1'b0;
      dqs_oe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      dq_oe_q  <= (state_q == ST_DATA);
      dqs_oe_q <= (state_q == ST_PRE) || (state_q == ST_DATA) || (state_q == ST_POST);
      dqs_d0_q <= (state_q == ST_DATA);
      dqs_d1_q <= 1'b0;
      dm_d0_q  <= '1;
      dm_d1_q  <= '1;
      // Clear first so a same-cycle underrun below overrides it
      if (underrun_clr) underrun_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (wr_start) begin
            if (WR_LATENCY > 0) begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_LOAD;
            end else begin
              state_q <= ST_PRE;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) state_q <= ST_PRE;
          else             cnt_q   <= cnt_q - CNT_ONE;
        end
        ST_PRE: begin
          state_q <= ST_DATA;
          cnt_q   <= PAIR_LOAD;
        end
        ST_DATA: begin
          if (wdata_valid) begin
            dq_d0_q <= wdata[2*DQ_WIDTH-1:DQ_WIDTH];
            dq_d1_q <= wdata[DQ_WIDTH-1:0];
            dm_d0_q <= wmask[2*DM_W-1:DM_W];
            dm_d1_q <= wmask[DM_W-1:0];
          end else begin
            // Missing beat pair: data repeats, bytes stay masked, burst still runs to length
            underrun_q <= 1'b1;
          end
          if (cnt_q == '0) state_q <= ST_POST;
          else             cnt_q   <= cnt_q - CNT_ONE;
        end
        ST_POST: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_busy     = (state_q != ST_IDLE);
  assign wdata_ready = (state_q == ST_DATA);
  assign dq_d0       = dq_d0_q;
  assign dq_d1       = dq_d1_q;
  assign dm_d0       = dm_d0_q;
  assign dm_d1       = dm_d1_q;
  assign dq_oe       = dq_oe_q;
  assign dqs_d0      = dqs_d0_q;
  assign dqs_d1      = dqs_d1_q;
  assign dqs_oe      = dqs_oe_q;
  assign underrun    = underrun_q;

endmodule
